// File: rtl/sample_tx_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : sample_tx_p (package)                                          |
// | Purpose : Shared types and helpers for the sample_tx serial transmitter. |
// |           - tx_state_t : transmitter FSM encoding                        |
// |           - frame_bits : bits per serial frame (data + optional parity)  |
// |           - parity     : even parity (XOR) of a zero-extended sample     |
// | Config  : SAMPLE_TX_PARITY_EN adds one parity bit to every frame.        |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package sample_tx_p;

   localparam int c_PARITY_MAX_W = 32;   // widest sample parity() accepts

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2
   } tx_state_t;

   function automatic int frame_bits(input int width);
`ifdef SAMPLE_TX_PARITY_EN
      return width + 1;
`else
      return width;
`endif
   endfunction

   // Caller zero-extends the sample; the extra zeros do not change the XOR.
   function automatic logic parity(input logic [c_PARITY_MAX_W-1:0] sample);
      return ^sample;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sample_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : sample_fifo                                                    |
// | Purpose : Small synchronous FIFO buffering filter samples ahead of the   |
// |           serializer. Pointers wrap modulo DEPTH (power of 2).           |
// | Ports   : clk   - clock                                                  |
// |           rst   - asynchronous active-low reset (empties the FIFO)       |
// |           push  - write request; refused only when full with no pop     |
// |           din   - write data                                             |
// |           pop   - read request (ignored when empty)                      |
// |           dout  - head of FIFO (valid when not empty)                    |
// |           full  - occupancy == DEPTH                                     |
// |           empty - occupancy == 0                                         |
// |           level - registered occupancy 0..DEPTH                          |
// |           drop  - push refused this cycle                                |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module sample_fifo
   import sample_tx_p::*;
#(
   parameter int WIDTH = 14,
   parameter int DEPTH = 4
)(
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic [WIDTH-1:0]             din,
   input  logic                         pop,
   output logic [WIDTH-1:0]             dout,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   level,
   output logic                         drop
);

   localparam int c_PTR_W = $clog2(DEPTH);
   localparam int c_LVL_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0]   r_mem [DEPTH];
   logic [c_PTR_W-1:0] r_wptr;
   logic [c_PTR_W-1:0] r_rptr;
   logic [c_LVL_W-1:0] r_level;
   logic               w_do_push;
   logic               w_do_pop;

   assign full  = (r_level == c_LVL_W'(DEPTH));
   assign empty = (r_level == '0);
   assign level = r_level;
   assign dout  = r_mem[r_rptr];

   // A pop in the same cycle frees a slot, so a push into a full FIFO
   // still succeeds when the head is leaving.
   assign w_do_pop  = pop & ~empty;
   assign w_do_push = push & (~full | w_do_pop);
   assign drop      = push & full & ~w_do_pop;

   // Storage needs no reset: only entries between the pointers are read.
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wptr] <= din;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
      end else begin
         if (w_do_push) begin
            r_wptr <= r_wptr + c_PTR_W'(1);
         end
         if (w_do_pop) begin
            r_rptr <= r_rptr + c_PTR_W'(1);
         end
         if (w_do_push && !w_do_pop) begin
            r_level <= r_level + c_LVL_W'(1);
         end else if (w_do_pop && !w_do_push) begin
            r_level <= r_level - c_LVL_W'(1);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/sample_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : sample_tx                                                      |
// | Purpose : Output-side transmitter for the decimating filter. Buffers     |
// |           strobed offset-binary samples in a FIFO and sends each one     |
// |           MSB-first in a cs_n/sclk/sdo frame. The host samples sdo on    |
// |           the rising edge of sclk.                                       |
// | Ports   : clk      - system clock                                        |
// |           rst      - asynchronous active-low reset                       |
// |           in       - sample from the filter output register              |
// |           in_stb   - one-cycle pulse, in holds a new sample              |
// |           in_valid - sample qualifier; invalid strobes are ignored       |
// |           ovf_clr  - clears overflow (a same-cycle set wins)             |
// |           sclk     - serial clock, idles low                             |
// |           sdo      - serial data                                         |
// |           cs_n     - frame select, active low                            |
// |           overflow - sticky, a sample was dropped on a full FIFO         |
// |           level    - registered FIFO occupancy                           |
// | Config  : SAMPLE_TX_PARITY_EN appends an even-parity bit after the LSB.  |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module sample_tx
   import sample_tx_p::*;
#(
   parameter int WIDTH    = 14,
   parameter int DEPTH    = 4,
   parameter int SCLK_DIV = 2,
   parameter int GAP      = 1
)(
   input  logic                         clk,
   input  logic                         rst,
   input  logic [WIDTH-1:0]             in,
   input  logic                         in_stb,
   input  logic                         in_valid,
   input  logic                         ovf_clr,
   output logic                         sclk,
   output logic                         sdo,
   output logic                         cs_n,
   output logic                         overflow,
   output logic [$clog2(DEPTH+1)-1:0]   level
);

   localparam int c_FRAME_BITS = frame_bits(WIDTH);
   localparam int c_BC_W       = $clog2(c_FRAME_BITS);
   localparam int c_GAP_CYC    = GAP * 2 * SCLK_DIV;
   // dc serves both as the sclk half-period divider and the inter-frame
   // gap timer, so it is sized for the longer of the two (the gap).
   localparam int c_DC_W       = (c_GAP_CYC > 1) ? $clog2(c_GAP_CYC) : 1;

   tx_state_t               r_state;
   tx_state_t               w_nxt_state;
   logic [c_FRAME_BITS-1:0] r_sr;
   logic [c_FRAME_BITS-1:0] w_nxt_sr;
   logic [c_BC_W-1:0]       r_bc;
   logic [c_BC_W-1:0]       w_nxt_bc;
   logic [c_DC_W-1:0]       r_dc;
   logic [c_DC_W-1:0]       w_nxt_dc;
   logic                    r_sclk;
   logic                    w_nxt_sclk;
   logic                    r_cs_n;
   logic                    w_nxt_cs_n;
   logic                    r_ovf;

   logic                    w_push;
   logic                    w_pop;
   logic [WIDTH-1:0]        w_dout;
   logic                    w_empty;
   logic                    w_unused_full;
   logic                    w_drop;
   logic [c_FRAME_BITS-1:0] w_load;

   assign w_push = in_stb & in_valid;

   sample_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (w_push),
      .din   (in),
      .pop   (w_pop),
      .dout  (w_dout),
      .full  (w_unused_full),
      .empty (w_empty),
      .level (level),
      .drop  (w_drop)
   );

   // Frame contents: the sample, optionally followed by its parity bit.
`ifdef SAMPLE_TX_PARITY_EN
   logic [c_PARITY_MAX_W-1:0] w_dout_ext;

   always_comb begin
      w_dout_ext              = '0;
      w_dout_ext[WIDTH-1:0]   = w_dout;
   end

   assign w_load = {w_dout, parity(w_dout_ext)};
`else
   assign w_load = w_dout;
`endif

   // sdo is the shift-register MSB. The final shift of a frame leaves sr
   // all-zero, which gives sdo=0 in GAP/IDLE without a separate register.
   assign sdo      = r_sr[c_FRAME_BITS-1];
   assign sclk     = r_sclk;
   assign cs_n     = r_cs_n;
   assign overflow = r_ovf;

   always_comb begin
      w_nxt_state = r_state;
      w_nxt_sr    = r_sr;
      w_nxt_bc    = r_bc;
      w_nxt_dc    = r_dc;
      w_nxt_sclk  = r_sclk;
      w_nxt_cs_n  = r_cs_n;
      w_pop       = 1'b0;

      unique case (r_state)
         IDLE: begin
            // Registered occupancy: a push into an empty FIFO is seen
            // one cycle later.
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_nxt_sr    = w_load;
               w_nxt_bc    = '0;
               w_nxt_dc    = '0;
               w_nxt_sclk  = 1'b0;
               w_nxt_cs_n  = 1'b0;
               w_nxt_state = SHIFT;
            end
         end

         SHIFT: begin
            if (r_dc == c_DC_W'(SCLK_DIV - 1)) begin
               w_nxt_dc = '0;
               if (!r_sclk) begin
                  w_nxt_sclk = 1'b1;
               end else begin
                  // Falling edge: advance to the next bit.
                  w_nxt_sclk = 1'b0;
                  w_nxt_sr   = {r_sr[c_FRAME_BITS-2:0], 1'b0};
                  if (r_bc == c_BC_W'(c_FRAME_BITS - 1)) begin
                     w_nxt_cs_n  = 1'b1;
                     // The parameter GAP shadows the enum literal here.
                     w_nxt_state = sample_tx_p::GAP;
                  end else begin
                     w_nxt_bc = r_bc + c_BC_W'(1);
                  end
               end
            end else begin
               w_nxt_dc = r_dc + c_DC_W'(1);
            end
         end

         sample_tx_p::GAP: begin
            if (r_dc == c_DC_W'(c_GAP_CYC - 1)) begin
               w_nxt_dc    = '0;
               w_nxt_state = IDLE;
            end else begin
               w_nxt_dc = r_dc + c_DC_W'(1);
            end
         end

         default: begin
            w_nxt_state = IDLE;
            w_nxt_sr    = '0;
            w_nxt_sclk  = 1'b0;
            w_nxt_cs_n  = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_sr    <= '0;
         r_bc    <= '0;
         r_dc    <= '0;
         r_sclk  <= 1'b0;
         r_cs_n  <= 1'b1;
      end else begin
         r_state <= w_nxt_state;
         r_sr    <= w_nxt_sr;
         r_bc    <= w_nxt_bc;
         r_dc    <= w_nxt_dc;
         r_sclk  <= w_nxt_sclk;
         r_cs_n  <= w_nxt_cs_n;
      end
   end

   // Sticky overflow; a drop in the same cycle as ovf_clr keeps it set.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ovf <= 1'b0;
      end else if (w_drop) begin
         r_ovf <= 1'b1;
      end else if (ovf_clr) begin
         r_ovf <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sample_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_sample_tx                                                   |
// | Purpose : Self-checking bench for sample_tx. Stimulus pushes expected    |
// |           frames into a scoreboard queue; a monitor decodes frames off   |
// |           cs_n/sclk/sdo and compares them against the queue head.        |
// | Config  : SAMPLE_TX_PARITY_EN selects the parity frame format.           |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_sample_tx;

   localparam int WIDTH    = 14;
   localparam int DEPTH    = 4;
   localparam int SCLK_DIV = 2;
   localparam int GAP_SCLK = 1;
`ifdef SAMPLE_TX_PARITY_EN
   localparam int FB = WIDTH + 1;
`else
   localparam int FB = WIDTH;
`endif
   localparam int FRAME_CYC = FB * 2 * SCLK_DIV;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [WIDTH-1:0] din = '0;
   logic             in_stb = 1'b0;
   logic             in_valid = 1'b0;
   logic             ovf_clr = 1'b0;
   logic             sclk;
   logic             sdo;
   logic             cs_n;
   logic             overflow;
   logic [2:0]       level;

   int n_cmp = 0;
   int n_err = 0;
   logic [FB-1:0] exp_q[$];

   sample_tx #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .SCLK_DIV (SCLK_DIV),
      .GAP      (GAP_SCLK)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in       (din),
      .in_stb   (in_stb),
      .in_valid (in_valid),
      .ovf_clr  (ovf_clr),
      .sclk     (sclk),
      .sdo      (sdo),
      .cs_n     (cs_n),
      .overflow (overflow),
      .level    (level)
   );

   always #5 clk = ~clk;

   function automatic logic [FB-1:0] expf(input logic [WIDTH-1:0] s);
`ifdef SAMPLE_TX_PARITY_EN
      return {s, ^s};
`else
      return s;
`endif
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Monitor: decode frames at the falling clk edge, away from DUT updates.
   initial begin
      logic          prev_cs;
      logic          prev_sclk;
      int            low_cnt;
      int            rises;
      logic [FB-1:0] got;
      logic [FB-1:0] want;
      prev_cs   = 1'b1;
      prev_sclk = 1'b0;
      low_cnt   = 0;
      rises     = 0;
      got       = '0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            // Reset aborts the frame in flight; it is never resumed.
            if (!prev_cs && exp_q.size() > 0) begin
               void'(exp_q.pop_front());
            end
            low_cnt = 0;
            rises   = 0;
            got     = '0;
         end else begin
            if (prev_cs && !cs_n) begin
               n_cmp++;
               if (exp_q.size() == 0) begin
                  n_err++;
                  $display("FAIL unexpected_frame: cs_n fell with no sample outstanding, expected none");
               end
               low_cnt = 0;
               rises   = 0;
               got     = '0;
            end
            if (!cs_n) begin
               low_cnt++;
               if (!prev_sclk && sclk) begin
                  got = {got[FB-2:0], sdo};
                  rises++;
               end
            end
            if (!prev_cs && cs_n && exp_q.size() > 0) begin
               want = exp_q.pop_front();
               n_cmp++;
               if (got !== want || rises != FB || low_cnt != FRAME_CYC) begin
                  n_err++;
                  $display("FAIL frame: got %0h (%0d rises, %0d low cycles), expected %0h (%0d rises, %0d low cycles)",
                           got, rises, low_cnt, want, FB, FRAME_CYC);
               end
            end
         end
         prev_cs   = cs_n;
         prev_sclk = sclk;
      end
   end

   task automatic drain(input string name, input int maxc);
      int c;
      c = 0;
      while (!(exp_q.size() == 0 && cs_n && level == 0) && c < maxc) begin
         @(negedge clk);
         c++;
      end
      chk(name, (c >= maxc) ? 32'd1 : 32'd0, 32'd0);
      repeat (2 * GAP_SCLK * 2 * SCLK_DIV + 4) @(negedge clk);
   endtask

   task automatic burst(input logic [WIDTH-1:0] s0, input logic [WIDTH-1:0] s1,
                        input logic [WIDTH-1:0] s2, input logic [WIDTH-1:0] s3,
                        input logic [WIDTH-1:0] s4, input logic [WIDTH-1:0] s5,
                        input logic clr_on_drop, input string tag);
      logic [WIDTH-1:0] v[6];
      v = '{s0, s1, s2, s3, s4, s5};
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i == 5) begin
            chk({tag, "_level_full"}, 32'(level), 32'd4);
            chk({tag, "_ovf_before_drop"}, 32'(overflow), 32'd0);
         end
         din      = v[i];
         in_stb   = 1'b1;
         in_valid = 1'b1;
         ovf_clr  = (i == 5) ? clr_on_drop : 1'b0;
         if (i < 5) exp_q.push_back(expf(v[i]));
      end
      @(negedge clk);
      in_stb  = 1'b0;
      ovf_clr = 1'b0;
      chk({tag, "_ovf_after_drop"}, 32'(overflow), 32'd1);
      chk({tag, "_level_after_drop"}, 32'(level), 32'd4);
   endtask

   initial begin
      int lows;
      int c;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_cs_n", 32'(cs_n), 32'd1);
      chk("rst_sclk", 32'(sclk), 32'd0);
      chk("rst_sdo", 32'(sdo), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_level", 32'(level), 32'd0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // Single sample 14'h2A5C, bits 10101001011100
      @(negedge clk);
      din = 14'h2A5C; in_stb = 1'b1; in_valid = 1'b1;
      exp_q.push_back(expf(14'b10101001011100));
      @(negedge clk);
      in_stb = 1'b0;
      chk("t1_level_after_push", 32'(level), 32'd1);
      chk("t1_cs_n_cycle1", 32'(cs_n), 32'd1);
      @(negedge clk);
      chk("t1_cs_n_cycle2", 32'(cs_n), 32'd0);
      chk("t1_sdo_first_bit", 32'(sdo), 32'd1);
      chk("t1_level_after_pop", 32'(level), 32'd0);
      drain("t1_drain", 500);

      // Invalid strobe is ignored
      @(negedge clk);
      din = 14'h3FFF; in_stb = 1'b1; in_valid = 1'b0;
      @(negedge clk);
      in_stb = 1'b0;
      chk("t2_level", 32'(level), 32'd0);
      lows = 0;
      repeat (80) begin
         @(negedge clk);
         if (!cs_n) lows++;
      end
      chk("t2_no_frame_cycles", 32'(lows), 32'd0);
      chk("t2_overflow", 32'(overflow), 32'd0);

      // Six back-to-back strobes: one in flight, four buffered, sixth dropped
      burst(14'h0001, 14'h2000, 14'h1555, 14'h2AAA, 14'h3FFF, 14'h0ABC, 1'b0, "t3");
      @(negedge clk);
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      chk("t3_ovf_cleared", 32'(overflow), 32'd0);
      drain("t3_drain", 1500);

      // ovf_clr in the same cycle as the dropping push: set wins
      burst(14'h1234, 14'h0F0F, 14'h3C3C, 14'h0003, 14'h2001, 14'h1111, 1'b1, "t4");
      @(negedge clk);
      chk("t4_ovf_still_set", 32'(overflow), 32'd1);
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      chk("t4_ovf_cleared", 32'(overflow), 32'd0);
      drain("t4_drain", 1500);

      // Reset halfway through a frame
      @(negedge clk);
      din = 14'h1234; in_stb = 1'b1; in_valid = 1'b1;
      exp_q.push_back(expf(14'h1234));
      @(negedge clk);
      in_stb = 1'b0;
      c = 0;
      while (cs_n && c < 20) begin
         @(negedge clk);
         c++;
      end
      chk("t5_frame_start_timeout", (c >= 20) ? 32'd1 : 32'd0, 32'd0);
      repeat (FRAME_CYC / 2) @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("t5_rst_cs_n", 32'(cs_n), 32'd1);
      chk("t5_rst_sclk", 32'(sclk), 32'd0);
      chk("t5_rst_sdo", 32'(sdo), 32'd0);
      chk("t5_rst_level", 32'(level), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      lows = 0;
      repeat (100) begin
         @(negedge clk);
         if (!cs_n) lows++;
      end
      chk("t5_no_resume_cycles", 32'(lows), 32'd0);
      chk("t5_abort_consumed", 32'(exp_q.size()), 32'd0);
      @(negedge clk);
      din = 14'h0F0F; in_stb = 1'b1; in_valid = 1'b1;
      exp_q.push_back(expf(14'h0F0F));
      @(negedge clk);
      in_stb = 1'b0;
      drain("t5_drain", 500);

`ifdef SAMPLE_TX_PARITY_EN
      // Parity bit: odd popcount -> 1, even popcount -> 0
      @(negedge clk);
      din = 14'h0001; in_stb = 1'b1; in_valid = 1'b1;
      exp_q.push_back(15'b000000000000011);
      @(negedge clk);
      in_stb = 1'b0;
      drain("t6a_drain", 500);
      @(negedge clk);
      din = 14'h0003; in_stb = 1'b1; in_valid = 1'b1;
      exp_q.push_back(15'b000000000000110);
      @(negedge clk);
      in_stb = 1'b0;
      drain("t6b_drain", 500);
`endif

      chk("end_queue_empty", 32'(exp_q.size()), 32'd0);
      chk("end_overflow", 32'(overflow), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sample_tx.md
Name: sample_tx

Overview:
- Output-side transmitter for the decimating filter.
- Accepts each downsampled `OUT_WIDTH`-bit offset-binary result, together with its strobe and valid flag, in the fast `clk` domain.
- Buffers results in a small FIFO and serializes them MSB-first over a 3-wire frame (`cs_n`/`sclk`/`sdo`) to an off-chip host.
- Sits after the filter's output register; it is the consumer end of the filter's sample interface.

Parameters:
- WIDTH, 14, sample width in bits; matches `OUT_WIDTH`.
- DEPTH, 4, FIFO depth in samples; power of 2, ≥2.
- SCLK_DIV, 2, `clk` cycles per `sclk` half-period; ≥1.
- GAP, 1, `sclk` periods with `cs_n` high between frames; ≥1.

Ports:
- clk  in  1  system clock (undivided filter clock).
- rst  in  1  asynchronous, active-low reset.
- in  in  WIDTH  sample from the filter output register.
- in_stb  in  1  one-cycle pulse: `in` holds a new sample.
- in_valid  in  1  filter valid flag; a strobe with `in_valid`=0 is ignored.
- ovf_clr  in  1  clears `overflow`.
- sclk  out  1  serial clock, idles low.
- sdo  out  1  serial data.
- cs_n  out  1  frame select, active low.
- overflow  out  1  sticky: a sample was dropped.
- level  out  $clog2(DEPTH+1)  FIFO occupancy.

Behaviour:
- Reset (`rst`=0, asynchronous), all outputs immediate:
  - `cs_n`=1, `sclk`=0, `sdo`=0, `overflow`=0, `level`=0.
  - FIFO emptied; FSM to IDLE.
  - Reset mid-frame aborts the frame at once; the partial frame is not resumed.
- Push:
  - Occurs when `in_stb` & `in_valid`.
  - Full and no pop in that cycle: drop the new sample; set `overflow` next cycle.
  - Full with a pop in the same cycle: push succeeds, no overflow.
- `overflow` is cleared by `ovf_clr`. If a set and `ovf_clr` occur in the same cycle, the set wins.
- `level` is registered. It updates the cycle after a push/pop and is unchanged on a simultaneous push+pop.
- FSM states IDLE, SHIFT, GAP:
  - IDLE: if the FIFO is non-empty (registered `level`>0), pop the head into shift register `sr`, clear bit counter `bc` and divider counter `dc`, go to SHIFT. Next cycle: `cs_n`=0, `sdo`=`sr[WIDTH-1]`, `sclk`=0.
  - A push into an empty FIFO is therefore seen one cycle later. First `cs_n` low is 2 cycles after the strobe.
  - SHIFT: `dc` counts 0..SCLK_DIV-1 and `sclk` toggles at each wrap.
    - `sdo` is stable across the rising edge (host samples on the rise).
    - On each falling edge `sr` shifts left, `sdo` takes the next bit and `bc` increments.
    - On the falling edge after bit `bc`=FRAME_BITS-1, `cs_n`=1, `sdo`=0, go to GAP.
  - Frame timing: `cs_n` low for exactly FRAME_BITS·2·SCLK_DIV cycles, with FRAME_BITS rising edges of `sclk` inside it.
  - GAP: hold `cs_n`=1, `sclk`=0 for GAP·2·SCLK_DIV cycles, then IDLE.
- Throughput:
  - Sample period = (FRAME_BITS+GAP)·2·SCLK_DIV + 1 cycles.
  - Must be ≤ DSR for lossless streaming; faster input fills the FIFO, then sets `overflow`.
- FIFO pointers wrap modulo DEPTH, with occupancy range 0..DEPTH.
- Samples are sent in push order, unmodified (offset-binary as produced by the filter).

Optional Feature:
- Macro: SAMPLE_TX_PARITY_EN.
- Defined: FRAME_BITS = WIDTH+1. After the data LSB one extra bit is sent: even parity, the XOR of all WIDTH data bits.
- Undefined: FRAME_BITS = WIDTH, no parity logic.

Decomposition:
- Package `sample_tx_p`:
  - state enum `tx_state_t` {IDLE, SHIFT, GAP}.
  - function `frame_bits(width)` returning FRAME_BITS under the macro.
  - function `parity(sample)`.
- One sub-module `sample_fifo`:
  - Parameters WIDTH, DEPTH.
  - Ports `clk`, `rst`, `push`, `din`, `pop`, `dout`, `full`, `empty`, `level`, `drop`.
  - Carries the same asynchronous active-low reset.
- The top holds the FSM, divider, shift register and overflow flag.

Test Plan:
- Reset then one strobe, `in`=14'h2A5C, `in_valid`=1, SCLK_DIV=2 → `cs_n` low 56 cycles starting 2 cycles after the strobe; `sdo` on `sclk` rises = 10101001011100; `level` 1→0.
- Strobe with `in_valid`=0, `in`=14'h3FFF → no frame, `level` stays 0, `overflow`=0.
- 6 strobes back-to-back 1 cycle apart, DEPTH=4 → first sample transmitted; 4 buffered (`level`=4); 6th dropped with `overflow`=1; frames 1..5 in order; `ovf_clr` → `overflow`=0.
- `ovf_clr` asserted in the same cycle as a dropping push → `overflow` remains 1.
- `rst` low halfway through a frame → `cs_n`=1, `sclk`=0, `sdo`=0 immediately; after release no frame until a new strobe; the next sample is sent whole.
- SAMPLE_TX_PARITY_EN defined, `in`=14'h0001 → 15 rising edges, final bit 1; `in`=14'h0003 → final bit 0.
